// File: rtl/quad_step_pkg.sv
// rtl/quad_step_pkg.sv - shared types and transition decode for the quadrature step decoder
package quad_step_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic [1:0] {DEC_NONE, DEC_UP, DEC_DOWN, DEC_ERR} dec_t;

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00, with {A,B} packing.
  function automatic quad_t quad_fwd(quad_t q);
    quad_t n;
    unique case (q)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  function automatic dec_t quad_decode(quad_t prev, quad_t next);
    dec_t d;
    if (prev == next)
      d = DEC_NONE;
    else if ((prev ^ next) == 2'b11)
      d = DEC_ERR;
    else if (next == quad_fwd(prev))
      d = DEC_UP;
    else
      d = DEC_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// rtl/quad_glitch_filter.sv - accepts a new A/B value after FILT_LEN identical sample ticks
module quad_glitch_filter
  import quad_step_pkg::*;
#(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_tick,
  input  logic [1:0] raw,
  output logic [1:0] filt,
  output logic       accept
);

  localparam int RUN_W = $clog2(FILT_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);

  quad_t            cand;
  logic [RUN_W-1:0] run;

  // accept rises on the same edge that filt takes the new value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      run    <= '0;
      filt   <= '0;
      accept <= 1'b0;
    end else begin
      accept <= 1'b0;
      if (sample_tick) begin
        if (raw != cand) begin
          cand <= raw;
          run  <= RUN_W'(1);
        end else if (run < RUN_MAX) begin
          run <= run + RUN_W'(1);
        end
      end
      if (run == RUN_MAX && cand != filt) begin
        filt   <= cand;
        accept <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature A/B step stream to up/down position count
module quad_step_decoder
  import quad_step_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DIV      = 8,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  quad_t            sync1, sync2;
  logic [DIV_W-1:0] div_cnt;
  logic             sample_tick;
  quad_t            filt, last;
  logic             accept, primed;
  dec_t             dec;
  logic             live, err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {quad_a, quad_b};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (en)
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
  end

  assign sample_tick = en && (div_cnt == DIV_LAST);

  quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .raw         (sync2),
    .filt        (filt),
    .accept      (accept)
  );

  // last holds the previously accepted value, so filt/last form the transition
  always_comb begin
    dec     = quad_decode(last, filt);
    live    = accept && primed;
    err_set = live && (dec == DEC_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last   <= '0;
      primed <= 1'b0;
      count  <= '0;
      dir    <= 1'b1;
      step   <= 1'b0;
      err    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (accept) begin
        last   <= filt;
        primed <= 1'b1;
      end
      if (live && dec == DEC_UP) begin
        count <= count + CNT_W'(1);
        dir   <= 1'b1;
        step  <= 1'b1;
      end else if (live && dec == DEC_DOWN) begin
        count <= count - CNT_W'(1);
        dir   <= 1'b0;
        step  <= 1'b1;
      end
      if (clr)
        count <= '0;
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule
